ghr_checkpoint: RTL and testbench
=================================

# ghr_checkpoint

Speculative global-history manager for the branch predictor front end. It holds the global history register (GHR) that feeds the history input of the PC/history hash that indexes the direction tables. It shifts the GHR on every conditional-branch prediction and records a checkpoint of the pre-prediction history in a circular queue. On a backend misprediction it restores the history from that checkpoint, with the corrected direction, and discards younger checkpoints.

## Interface
- HIST_width, 14, GHR width; equals the history width of the hash.
- DEPTH, 8, number of in-flight checkpoints; power of two, ≥2.
- TAG_width, $clog2(DEPTH), checkpoint tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  synchronous active-low reset.
- pred_valid  in  1  frontend issues one conditional-branch prediction this cycle.
- pred_taken  in  1  predicted direction.
- pred_ready  out  1  queue can accept a prediction (not full).
- pred_tag  out  TAG_width  tag allocated to the current prediction; equals the tail index.
- ghr  out  HIST_width  speculative history; drives the hash history input.
- cmt_valid  in  1  oldest branch retired; frees the head checkpoint.
- flush_valid  in  1  branch with flush_tag resolved as mispredicted.
- flush_tag  in  TAG_width  tag of the mispredicted branch.
- flush_taken  in  1  actual direction of that branch.
- count  out  TAG_width+1  occupied checkpoints, 0..DEPTH.
- flush_cnt  out  32  number of accepted flushes (see Configuration).

## Operation
- State: ghr register; ckpt[DEPTH] of HIST_width; head and tail pointers, each TAG_width+1 bits wide, with the MSB as the wrap bit.
- count = tail − head, modulo 2^(TAG_width+1). A full queue (count == DEPTH) and an empty queue (count == 0) are therefore distinguishable.
- pred_ready = (count != DEPTH); pred_tag = tail[TAG_width-1:0].
- Prediction accepted (pred_valid & pred_ready & !flush_valid):
  - ckpt[tail] ← ghr.
  - ghr ← {ghr[HIST_width-2:0], pred_taken}.
  - tail ← tail+1.
- Prediction with pred_ready=0: ignored. ghr, ckpt and tail are unchanged. The frontend must stall.
- Commit (cmt_valid & count!=0): head ← head+1. Commit when empty is ignored.
- Flush (flush_valid):
  - ghr ← {ckpt[flush_tag][HIST_width-2:0], flush_taken}.
  - tail ← the pointer whose index is flush_tag+1 and which lies in the window (head, tail]. The checkpoint of the flushed branch is kept until it commits.
  - Any prediction in the same cycle is dropped, regardless of pred_ready.
- Simultaneous commit and flush: both apply.
  - head advances and tail is set as above.
  - If flush_tag equals the head index, the result is count = 0.
- flush_tag outside the occupied window: illegal. The design behaviour is unspecified, and the bench asserts that it never occurs.
- No state machine beyond the pointers. The queue is strictly in-order; only a flush truncates it.

## Timing
- Reset (rstn=0 at an edge) sets: ghr=0, head=tail=0, count=0, pred_ready=1, pred_tag=0, flush_cnt=0. ckpt contents are don't-care.
- Reset has priority over all inputs. Reset asserted mid-flush or mid-burst discards all checkpoints.
- ghr, count, pred_ready and flush_cnt are registered outputs. pred_tag is a function of registered tail only.
- Latency:
  - Accepted prediction at edge N: new ghr visible after edge N. A back-to-back prediction at N+1 hashes with the updated history.
  - Flush at edge N: restored ghr and new count visible after edge N. The redirected fetch at N+1 uses the corrected history.
- Wrap-around: pointer indices wrap modulo DEPTH and wrap bits toggle. The full/empty distinction must hold across an arbitrary number of wraps.

## Configuration
- GHR_PERF_CNT_EN defined:
  - flush_cnt increments by 1 on every cycle with flush_valid=1 (reset value 0).
  - It wraps at 2^32.
- GHR_PERF_CNT_EN undefined:
  - The counter register is not built.
  - flush_cnt is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then predictions T,T,N,T (one per cycle, defaults) → ghr = 14'b1101, count=4, pred_tags issued 0,1,2,3; ckpt[3]=14'b110.
- 8 predictions with no commit → pred_ready=0 and count=8. A 9th pred_valid leaves ghr and tail unchanged. One cmt_valid → pred_ready=1 on the next cycle.
- 4 predictions from ghr=0 (T,T,T,T), then flush tag 1 with flush_taken=0 → ghr = 14'b10, count=2, next pred_tag=2.
- Same cycle: pred_valid=1 with flush_valid=1 (tag 0, taken=1) on a queue of 3 → prediction dropped, ghr=14'b1, count=1.
- Same cycle: commit and flush both on head tag 0 with count=1 → count=0, pred_ready=1, ghr = {ckpt[0][12:0], flush_taken}.
- Run 40 predict/commit cycles (pointer wraps ≥4 times) with GHR_PERF_CNT_EN defined and 5 flushes → count matches the reference model every cycle and flush_cnt=5. Without the macro, flush_cnt stays 0.

Source files
------------

// File: rtl/ghr_checkpoint.sv
// Speculative global-history register with an in-order checkpoint queue for misprediction recovery.
// Optional flush performance counter enabled by defining GHR_PERF_CNT_EN.
module ghr_checkpoint #(
    parameter int unsigned HIST_width = 14,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TAG_width  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  pred_valid,
    input  logic                  pred_taken,
    output logic                  pred_ready,
    output logic [TAG_width-1:0]  pred_tag,
    output logic [HIST_width-1:0] ghr,
    input  logic                  cmt_valid,
    input  logic                  flush_valid,
    input  logic [TAG_width-1:0]  flush_tag,
    input  logic                  flush_taken,
    output logic [TAG_width:0]    count,
    output logic [31:0]           flush_cnt
);

    localparam int unsigned PTR_W = TAG_width + 1;

    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W-1:0]      head_d;
    logic [PTR_W-1:0]      tail_d;
    logic [PTR_W-1:0]      count_d;
    logic                  ready_d;
    logic [HIST_width-1:0] ghr_d;
    logic [TAG_width-1:0]  flush_off;
    logic                  pred_accept;
    logic                  cmt_accept;
    logic [HIST_width-1:0] ckpt [DEPTH];

    // count register always mirrors tail - head, so it doubles as the occupancy.
    always_comb begin
        head_d      = head;
        tail_d      = tail;
        ghr_d       = ghr;
        pred_accept = pred_valid & pred_ready & ~flush_valid;
        cmt_accept  = cmt_valid & (count != '0);
        flush_off   = flush_tag - head[TAG_width-1:0];

        if (cmt_accept) begin
            head_d = head + PTR_W'(1);
        end

        // Flush rebuilds tail from head so the wrap bit is correct; the flushed entry is kept.
        if (flush_valid) begin
            ghr_d  = {ckpt[flush_tag][HIST_width-2:0], flush_taken};
            tail_d = head + PTR_W'(flush_off) + PTR_W'(1);
        end else if (pred_accept) begin
            ghr_d  = {ghr[HIST_width-2:0], pred_taken};
            tail_d = tail + PTR_W'(1);
        end

        count_d = tail_d - head_d;
        ready_d = (count_d != PTR_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head       <= '0;
            tail       <= '0;
            ghr        <= '0;
            count      <= '0;
            pred_ready <= 1'b1;
        end else begin
            head       <= head_d;
            tail       <= tail_d;
            ghr        <= ghr_d;
            count      <= count_d;
            pred_ready <= ready_d;
        end
    end

    // Checkpoint storage needs no reset; entries are only read inside the occupied window.
    always_ff @(posedge clk) begin
        if (rstn && pred_accept) begin
            ckpt[tail[TAG_width-1:0]] <= ghr;
        end
    end

    assign pred_tag = tail[TAG_width-1:0];

`ifdef GHR_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            flush_cnt <= '0;
        end else if (flush_valid) begin
            flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ghr_checkpoint.sv
// Bench for ghr_checkpoint: directed vector table, hand-written reset/flush sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_ghr_checkpoint;

    localparam int unsigned HW    = 14;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TW    = 3;

    logic          clk;
    logic          rstn;
    logic          pred_valid;
    logic          pred_taken;
    logic          pred_ready;
    logic [TW-1:0] pred_tag;
    logic [HW-1:0] ghr;
    logic          cmt_valid;
    logic          flush_valid;
    logic [TW-1:0] flush_tag;
    logic          flush_taken;
    logic [TW:0]   count;
    logic [31:0]   flush_cnt;

    ghr_checkpoint #(.HIST_width(HW), .DEPTH(DEPTH), .TAG_width(TW)) dut (
        .clk(clk), .rstn(rstn),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_ready(pred_ready), .pred_tag(pred_tag), .ghr(ghr),
        .cmt_valid(cmt_valid),
        .flush_valid(flush_valid), .flush_tag(flush_tag), .flush_taken(flush_taken),
        .count(count), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          rst_n;
        logic          pv, pt, cv, fv;
        logic [TW-1:0] ft;
        logic          fk;
        logic [HW-1:0] e_ghr;
        logic [TW:0]   e_cnt;
        logic          e_rdy;
        logic [TW-1:0] e_tag;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int r, input int pv, input int pt, input int cv,
                                input int fv, input int ft, input int fk,
                                input int eg, input int ec, input int er, input int et);
        vec_t v;
        v.rst_n = 1'(r);  v.pv = 1'(pv); v.pt = 1'(pt); v.cv = 1'(cv);
        v.fv = 1'(fv);    v.ft = TW'(ft); v.fk = 1'(fk);
        v.e_ghr = HW'(eg); v.e_cnt = (TW+1)'(ec); v.e_rdy = 1'(er); v.e_tag = TW'(et);
        return v;
    endfunction

    // Reference model: ordered list of saved histories; tags derived from the head index.
    logic [HW-1:0] m_q[$];
    logic [HW-1:0] m_ghr;
    int            m_head;
    int            m_flushes;

    function automatic void model_reset();
        m_q.delete();
        m_ghr = '0;
        m_head = 0;
        m_flushes = 0;
    endfunction

    function automatic void model_step(input logic pv, input logic pt, input logic cv,
                                       input logic fv, input logic [TW-1:0] ft, input logic fk);
        int size;
        int pos;
        logic [HW-1:0] saved;
        size = m_q.size();
        if (fv) begin
            pos = (int'(ft) - m_head + DEPTH) % DEPTH;
            assert (pos < size) else $error("FAIL illegal_flush_tag: tag %0d outside window", ft);
            saved = m_q[pos];
            m_ghr = {saved[HW-2:0], fk};
            while (m_q.size() > pos + 1) void'(m_q.pop_back());
            m_flushes++;
        end else if (pv && size != DEPTH) begin
            m_q.push_back(m_ghr);
            m_ghr = {m_ghr[HW-2:0], pt};
        end
        if (cv && size != 0) begin
            void'(m_q.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
    endfunction

    function automatic int exp_fcnt(input int n);
`ifdef GHR_PERF_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic drive(input logic r, input logic pv, input logic pt, input logic cv,
                         input logic fv, input logic [TW-1:0] ft, input logic fk);
        rstn = r; pred_valid = pv; pred_taken = pt; cmt_valid = cv;
        flush_valid = fv; flush_tag = ft; flush_taken = fk;
    endtask

    initial begin
        int hist;
        drive(1'b0, 0, 0, 0, 0, '0, 0);

        // Directed table: ghr, count, pred_ready, pred_tag after each edge.
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 14'h0,   0,1,0));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'h1,   1,1,1));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'h3,   2,1,2));
        tbl.push_back(mk(1, 1,0,0, 0,0,0, 14'h6,   3,1,3));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'hD,   4,1,4));
        tbl.push_back(mk(1, 0,0,0, 1,3,0, 14'hC,   4,1,4));
        tbl.push_back(mk(1, 0,0,1, 0,0,0, 14'hC,   3,1,4));
        tbl.push_back(mk(1, 0,0,1, 0,0,0, 14'hC,   2,1,4));
        tbl.push_back(mk(1, 0,0,1, 0,0,0, 14'hC,   1,1,4));
        tbl.push_back(mk(1, 0,0,1, 0,0,0, 14'hC,   0,1,4));
        tbl.push_back(mk(1, 0,0,1, 0,0,0, 14'hC,   0,1,4));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'h19,  1,1,5));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'h33,  2,1,6));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'h67,  3,1,7));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'hCF,  4,1,0));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'h19F, 5,1,1));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'h33F, 6,1,2));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'h67F, 7,1,3));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'hCFF, 8,0,4));
        tbl.push_back(mk(1, 1,0,0, 0,0,0, 14'hCFF, 8,0,4));
        tbl.push_back(mk(1, 0,0,1, 0,0,0, 14'hCFF, 7,1,4));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 14'h0,   0,1,0));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'h1,   1,1,1));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'h3,   2,1,2));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'h7,   3,1,3));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'hF,   4,1,4));
        tbl.push_back(mk(1, 0,0,0, 1,1,0, 14'h2,   2,1,2));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 14'h0,   0,1,0));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'h1,   1,1,1));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'h3,   2,1,2));
        tbl.push_back(mk(1, 1,1,0, 0,0,0, 14'h7,   3,1,3));
        tbl.push_back(mk(1, 1,1,0, 1,0,1, 14'h1,   1,1,1));
        tbl.push_back(mk(1, 0,0,1, 1,0,1, 14'h1,   0,1,1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].pv, tbl[i].pt, tbl[i].cv, tbl[i].fv, tbl[i].ft, tbl[i].fk);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_ghr", i), 32'(ghr), 32'(tbl[i].e_ghr));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_ready", i), 32'(pred_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_tag", i), 32'(pred_tag), 32'(tbl[i].e_tag));
        end

        // Reset asserted during a flush with a prediction pending discards everything.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1, 1, 0, 0, '0, 0);
            @(posedge clk); #1;
        end
        drive(1'b0, 1, 1, 1, 1, TW'(1), 1);
        @(posedge clk); #1;
        chk("rst_mid_flush_ghr", 32'(ghr), 32'h0);
        chk("rst_mid_flush_count", 32'(count), 32'h0);
        chk("rst_mid_flush_tag", 32'(pred_tag), 32'h0);
        chk("rst_mid_flush_fcnt", flush_cnt, 32'h0);
        drive(1'b1, 1, 1, 0, 0, '0, 0);
        @(posedge clk); #1;
        drive(1'b1, 0, 0, 0, 1, TW'(0), 0);
        @(posedge clk); #1;
        chk("post_rst_flush_ghr", 32'(ghr), 32'h0);
        chk("post_rst_flush_count", 32'(count), 32'h1);
        chk("post_rst_flush_fcnt", flush_cnt, 32'(exp_fcnt(1)));

        // Randomized traffic against the reference model.
        drive(1'b0, 0, 0, 0, 0, '0, 0);
        @(posedge clk); #1;
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic pv, pt, cv, fv, fk;
            logic [TW-1:0] ft;
            pv = ($urandom_range(0, 99) < 70);
            pt = 1'($urandom);
            cv = ($urandom_range(0, 99) < 35);
            fv = (m_q.size() != 0) && ($urandom_range(0, 99) < 6);
            fk = 1'($urandom);
            ft = '0;
            if (fv) ft = TW'((m_head + int'($urandom_range(0, m_q.size() - 1))) % DEPTH);
            drive(1'b1, pv, pt, cv, fv, ft, fk);
            model_step(pv, pt, cv, fv, ft, fk);
            @(posedge clk); #1;
            hist = int'(m_ghr);
            chk($sformatf("rnd%0d_ghr", cyc), 32'(ghr), 32'(hist));
            chk($sformatf("rnd%0d_count", cyc), 32'(count), 32'(m_q.size()));
            chk($sformatf("rnd%0d_ready", cyc), 32'(pred_ready), 32'(m_q.size() != DEPTH));
            chk($sformatf("rnd%0d_tag", cyc), 32'(pred_tag), 32'((m_head + m_q.size()) % DEPTH));
            chk($sformatf("rnd%0d_fcnt", cyc), flush_cnt, 32'(exp_fcnt(m_flushes)));
        end

        drive(1'b1, 0, 0, 0, 0, '0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
